// File: rtl/serial_code_pkg.sv
// Shared encodings for the serial BCD/Excess-3 codec: mode codes, per-mode
// constants, FSM states and the digit legality check.
package serial_code_pkg;

  typedef enum logic {
    MODE_ADD3 = 1'b0,
    MODE_SUB3 = 1'b1
  } mode_e;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  localparam logic [3:0] K_ADD3 = 4'b0011;
  localparam logic [3:0] K_SUB3 = 4'b1101;

  // BCD input must be 0..9; XS3 input must be 3..12.
  function automatic logic digit_illegal(input logic m, input logic [3:0] d);
    if (m == MODE_SUB3) return (d < 4'd3) || (d > 4'd12);
    else                return d > 4'd9;
  endfunction

endpackage

// File: rtl/serial_const_adder.sv
// One-bit serial adder with carry register; the carry input is forced to
// zero on the first bit of each digit.
module serial_const_adder (
  input  logic clock,
  input  logic reset,
  input  logic x,
  input  logic k,
  input  logic first,
  input  logic en,
  output logic z
);

  logic carry_q;
  logic cin;

  always_comb begin
    cin = first ? 1'b0 : carry_q;
    z   = x ^ k ^ cin;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      carry_q <= 1'b0;
    end else if (en) begin
      carry_q <= (x & k) | (x & cin) | (k & cin);
    end
  end

endmodule

// File: rtl/serial_bcd_xs3_codec.sv
// Bit-serial LSB-first BCD<->Excess-3 converter over frames of DIGITS digits,
// with valid/stall, frame framing, per-digit legality and sticky frame error.
module serial_bcd_xs3_codec
  import serial_code_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic x,
  input  logic x_valid,
  input  logic x_start,
  input  logic mode,
  output logic z,
  output logic z_valid,
  output logic z_last,
  output logic digit_err,
  output logic frame_err
);

  localparam int unsigned   DW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DW-1:0] LAST_DIG = DW'(DIGITS - 1);

  state_e        state_q, state_d;
  logic [1:0]    bit_cnt;
  logic [DW-1:0] dig_cnt;
  logic [2:0]    shift_q;
  logic          mode_q;

  logic          accept;
  logic          m;
  logic [1:0]    pos;
  logic [DW-1:0] dpos;
  logic [3:0]    kvec;
  logic          bit3;
  logic          z_raw;

  // x_start overrides the stored position so a restart always lands on bit0/digit0.
  always_comb begin
    accept    = x_valid & ((state_q == ACTIVE) | x_start);
    m         = x_start ? mode : mode_q;
    pos       = x_start ? 2'd0 : bit_cnt;
    dpos      = x_start ? '0 : dig_cnt;
    kvec      = (m == MODE_SUB3) ? K_SUB3 : K_ADD3;
    bit3      = (pos == 2'd3);
    z_valid   = accept;
    z         = accept & z_raw;
    z_last    = accept & bit3 & (dpos == LAST_DIG);
    digit_err = accept & bit3 & digit_illegal(m, {x, shift_q});

    state_d = state_q;
    if (x_valid && x_start) begin
      state_d = ACTIVE;
    end else if (z_last) begin
      state_d = IDLE;
    end
  end

  serial_const_adder u_adder (
    .clock (clock),
    .reset (reset),
    .x     (x),
    .k     (kvec[pos]),
    .first (pos == 2'd0),
    .en    (accept),
    .z     (z_raw)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      bit_cnt   <= '0;
      dig_cnt   <= '0;
      shift_q   <= '0;
      mode_q    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        bit_cnt <= pos + 2'd1;
        if (bit3) begin
          dig_cnt <= (dpos == LAST_DIG) ? '0 : dpos + DW'(1);
        end else begin
          dig_cnt      <= dpos;
          shift_q[pos] <= x;
        end
        if (x_start) begin
          mode_q    <= mode;
          frame_err <= digit_err;
        end else if (digit_err) begin
          frame_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_bcd_xs3_codec.sv
// Self-checking bench for serial_bcd_xs3_codec with DIGITS=1 and DIGITS=2 instances.
module tb_serial_bcd_xs3_codec;

  logic clock = 1'b0;
  logic reset;
  logic x, x_start, mode;
  logic xv1, xv2;
  logic z1, zv1, zl1, de1, fe1;
  logic z2, zv2, zl2, de2, fe2;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic z;
    logic last;
    logic derr;
  } exp_t;

  exp_t exp_q[$];
  logic exp_ferr1 = 1'b0;
  logic exp_ferr2 = 1'b0;

  always #5 clock = ~clock;

  serial_bcd_xs3_codec #(.DIGITS(1)) dut1 (
    .clock(clock), .reset(reset), .x(x), .x_valid(xv1), .x_start(x_start), .mode(mode),
    .z(z1), .z_valid(zv1), .z_last(zl1), .digit_err(de1), .frame_err(fe1)
  );

  serial_bcd_xs3_codec #(.DIGITS(2)) dut2 (
    .clock(clock), .reset(reset), .x(x), .x_valid(xv2), .x_start(x_start), .mode(mode),
    .z(z2), .z_valid(zv2), .z_last(zl2), .digit_err(de2), .frame_err(fe2)
  );

  function automatic logic ref_illegal(input logic md, input logic [3:0] d);
    if (md) return (d < 4'd3) || (d > 4'd12);
    return d > 4'd9;
  endfunction

  // Pushes expectations for a whole frame, then drives the first nbits of it.
  task automatic send_frame(input int sel, input logic md, input logic [3:0] d0,
                            input logic [3:0] d1, input int nbits, input int max_stall);
    int nd;
    logic [3:0] dv, rv;
    exp_t e;
    logic oz, ov, ol, od, of;
    nd = (sel == 1) ? 1 : 2;
    for (int di = 0; di < nd; di++) begin
      dv = (di == 0) ? d0 : d1;
      rv = md ? dv - 4'd3 : dv + 4'd3;
      for (int b = 0; b < 4; b++) begin
        e.z    = rv[b];
        e.last = (di == nd - 1) && (b == 3);
        e.derr = (b == 3) && ref_illegal(md, dv);
        exp_q.push_back(e);
      end
    end
    for (int i = 0; i < nbits; i++) begin
      if (max_stall > 0 && i > 0) begin
        repeat ($urandom_range(1, max_stall)) begin
          @(negedge clock);
          xv1 = 1'b0; xv2 = 1'b0; x = 1'($urandom_range(0, 1)); x_start = 1'b0;
          #1;
          ov = (sel == 1) ? zv1 : zv2;
          oz = (sel == 1) ? z1 : z2;
          checks++;
          if (ov !== 1'b0 || oz !== 1'b0) begin
            failures++;
            $display("FAIL stall_quiet: z_valid=%b z=%b required 0 0", ov, oz);
          end
        end
      end
      @(negedge clock);
      dv = ((i / 4) == 0) ? d0 : d1;
      x = dv[i % 4]; x_start = (i == 0); mode = md;
      xv1 = (sel == 1); xv2 = (sel == 2);
      #1;
      e  = exp_q.pop_front();
      oz = (sel == 1) ? z1 : z2;
      ov = (sel == 1) ? zv1 : zv2;
      ol = (sel == 1) ? zl1 : zl2;
      od = (sel == 1) ? de1 : de2;
      checks++;
      if (ov !== 1'b1 || oz !== e.z || ol !== e.last || od !== e.derr) begin
        failures++;
        $display("FAIL bit dut%0d idx%0d: valid/z/last/err=%b%b%b%b required 1%b%b%b",
                 sel, i, ov, oz, ol, od, e.z, e.last, e.derr);
      end
      if (sel == 1) exp_ferr1 = (i == 0) ? e.derr : (exp_ferr1 | e.derr);
      else          exp_ferr2 = (i == 0) ? e.derr : (exp_ferr2 | e.derr);
      @(posedge clock);
      #1;
      xv1 = 1'b0; xv2 = 1'b0; x_start = 1'b0;
      of = (sel == 1) ? fe1 : fe2;
      checks++;
      if (of !== ((sel == 1) ? exp_ferr1 : exp_ferr2)) begin
        failures++;
        $display("FAIL frame_err dut%0d idx%0d: got %b required %b", sel, i, of,
                 (sel == 1) ? exp_ferr1 : exp_ferr2);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0; x = 1'b1; x_start = 1'b0; mode = 1'b0; xv1 = 1'b1; xv2 = 1'b1;
    #3;
    checks++;
    if ({zv1, z1, zl1, de1, fe1, zv2, z2, zl2, de2, fe2} !== 10'b0) begin
      failures++;
      $display("FAIL reset_outputs: got %b required 0000000000",
               {zv1, z1, zl1, de1, fe1, zv2, z2, zl2, de2, fe2});
    end
    xv1 = 1'b0; xv2 = 1'b0; x = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_single_digit();
    send_frame(1, 1'b0, 4'd5, 4'd0, 4, 0);
    send_frame(1, 1'b0, 4'd9, 4'd0, 4, 0);
  endtask

  task automatic test_two_digit();
    send_frame(2, 1'b0, 4'd9, 4'd0, 8, 0);
    send_frame(2, 1'b0, 4'd7, 4'd3, 8, 0);
  endtask

  task automatic test_stalls();
    send_frame(2, 1'b0, 4'd9, 4'd0, 8, 3);
    send_frame(1, 1'b1, 4'd8, 4'd0, 4, 3);
  endtask

  task automatic test_illegal_bcd();
    send_frame(1, 1'b0, 4'd11, 4'd0, 4, 0);
    send_frame(1, 1'b0, 4'd2, 4'd0, 4, 0);
    send_frame(1, 1'b0, 4'd15, 4'd0, 4, 0);
  endtask

  task automatic test_xs3_decode();
    send_frame(2, 1'b1, 4'd12, 4'd1, 8, 0);
    send_frame(2, 1'b1, 4'd13, 4'd3, 8, 0);
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 6; f++) begin
      send_frame(2, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 8, f % 2);
    end
  endtask

  task automatic test_reset_restart();
    send_frame(2, 1'b1, 4'd1, 4'd5, 3, 0);
    send_frame(2, 1'b1, 4'd1, 4'd5, 6, 0);
    @(negedge clock);
    xv2 = 1'b1; x = 1'b1; x_start = 1'b0;
    #2 reset = 1'b0;
    #1;
    exp_ferr1 = 1'b0; exp_ferr2 = 1'b0;
    checks++;
    if ({zv2, z2, zl2, de2, fe2} !== 5'b0) begin
      failures++;
      $display("FAIL midframe_reset: got %b required 00000", {zv2, z2, zl2, de2, fe2});
    end
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      x = 1'($urandom_range(0, 1)); xv2 = 1'b1; x_start = 1'b0;
      #1;
      checks++;
      if (zv2 !== 1'b0 || z2 !== 1'b0 || fe2 !== 1'b0) begin
        failures++;
        $display("FAIL ignored_after_reset: valid=%b z=%b ferr=%b required 0 0 0", zv2, z2, fe2);
      end
    end
    xv2 = 1'b0;
    send_frame(2, 1'b0, 4'd7, 4'd9, 5, 0);
    send_frame(2, 1'b0, 4'd5, 4'd8, 8, 0);
  endtask

  initial begin
    test_reset();
    test_single_digit();
    test_two_digit();
    test_stalls();
    test_illegal_bcd();
    test_xs3_decode();
    test_back_to_back();
    test_reset_restart();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
